// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encodings, parity
// selector values and default widths. Build option: UART_TX_FIFO_EN.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PRESCALE_W = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Parity bit from the XOR-reduction of the data word.
  function automatic logic parity_bit(input logic data_xor, input logic ptype);
    return (ptype == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding accepted words plus their frame settings.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
// Used by uart_tx_cfg only when UART_TX_FIFO_EN is defined.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push and a pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional parity, one or two stop bits, internal per-bit baud timer.
// Build option UART_TX_FIFO_EN: a FIFO_DEPTH-entry FIFO buffers accepted words;
// otherwise a single holding register is used and FIFO_DEPTH is ignored.
//
// state     | meaning
// TX_IDLE   | line high, waiting for a pending word
// TX_START  | start bit (line low) for one bit time
// TX_DATA   | data bits, LSB first, bit_idx 0..DATA_WIDTH-1
// TX_PARITY | parity bit, only when the frame was accepted with parity enabled
// TX_STOP   | stop bit(s), one or two bit times of line high
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  ready,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  stop_bits,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  busy,
  output logic                  TX_OUT
);

  // Snapshot layout: {prescale, stop_bits, parity_type, parity_enable, word}
  localparam int SNAP_W = DATA_WIDTH + 3 + PRESCALE_W;
  localparam int IDX_W  = $clog2(DATA_WIDTH);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_cfg: DATA_WIDTH must be in 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 >= 2");
  end

  tx_state_e state, state_nxt;

  logic                  accept;
  logic                  load;
  logic                  pend_valid;
  logic [SNAP_W-1:0]     in_snap;
  logic [SNAP_W-1:0]     pend_snap;

  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_par_en;
  logic                  pend_par_type;
  logic                  pend_stop2;
  logic [PRESCALE_W-1:0] pend_presc;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_bit;
  logic                  cur_par_en;
  logic                  cur_stop2;
  logic [PRESCALE_W-1:0] cur_presc;
  logic [PRESCALE_W-1:0] bit_cnt;
  logic [PRESCALE_W-1:0] bit_last;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic                  tc;
  logic                  last_data;
  logic                  last_stop;
  logic                  line_bit;

  assign in_snap       = {prescale, stop_bits, parity_type, parity_enable, P_DATA};
  assign accept        = Data_Valid && ready;

  assign pend_data     = pend_snap[DATA_WIDTH-1:0];
  assign pend_par_en   = pend_snap[DATA_WIDTH];
  assign pend_par_type = pend_snap[DATA_WIDTH+1];
  assign pend_stop2    = pend_snap[DATA_WIDTH+2];
  assign pend_presc    = pend_snap[SNAP_W-1:DATA_WIDTH+3];

  assign busy          = (state != TX_IDLE);

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (accept),
    .wr_data (in_snap),
    .rd_en   (load),
    .rd_data (pend_snap),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pend_valid = !fifo_empty;
  assign ready      = !fifo_full;
`else
  logic              hold_full;
  logic [SNAP_W-1:0] hold_snap;

  // Single holding register: filled on accept, emptied when the FSM starts the frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_full <= 1'b0;
      hold_snap <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_snap <= in_snap;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  assign pend_snap  = hold_snap;
  assign pend_valid = hold_full;
  assign ready      = !busy && !hold_full;
`endif

  // A prescale of 0 behaves as 1, so the terminal count is then 0.
  assign bit_last  = (cur_presc == '0) ? '0 : cur_presc - PRESCALE_W'(1);
  assign tc        = (bit_cnt == bit_last);
  assign last_data = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign last_stop = !cur_stop2 || stop_idx;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= TX_IDLE;
    else     state <= state_nxt;
  end

  // Next-state, frame load request and the line value for the current state.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    line_bit  = 1'b1;
    case (state)
      TX_IDLE: begin
        if (pend_valid) begin
          load      = 1'b1;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        line_bit = 1'b0;
        if (tc) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        line_bit = shift_reg[0];
        if (tc && last_data) state_nxt = cur_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        line_bit = par_bit;
        if (tc) state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (tc && last_stop) begin
          if (pend_valid) begin
            load      = 1'b1;
            state_nxt = TX_START;
          end else begin
            state_nxt = TX_IDLE;
          end
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Frame datapath: snapshot on load, then bit timer, shifter and stop counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      cur_par_en <= 1'b0;
      cur_stop2  <= 1'b0;
      cur_presc  <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
    end else if (load) begin
      shift_reg  <= pend_data;
      par_bit    <= parity_bit(^pend_data, pend_par_type);
      cur_par_en <= pend_par_en;
      cur_stop2  <= pend_stop2;
      cur_presc  <= pend_presc;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
    end else if (state != TX_IDLE) begin
      if (tc) begin
        bit_cnt <= '0;
        if (state == TX_DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + 1'b1;
        end
        if (state == TX_STOP) stop_idx <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Registered line output; idles high and returns high right after reset.
  always_ff @(posedge CLK) begin
    if (RST) TX_OUT <= 1'b1;
    else     TX_OUT <= line_bit;
  end

endmodule
